// File: rtl/mul_sched_pkg.sv
// Shared definitions for the shared-multiplier scheduler.
//  - Default widths/latency of the time-shared signed multiplier.
//  - tag_t: one stage of the requester-tag pipe that travels alongside the
//    multiplier pipeline ({vld, id}).
//  - onehot(): requester id -> one-hot vector (NREQ_MAX wide; callers size-cast).
package mul_sched_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int IN_W_DEF    = 32;
  localparam int OUT_W_DEF   = 58;
  localparam int MUL_LAT_DEF = 4;

  // Tag id is sized for the largest supported requester count (8).
  localparam int NREQ_MAX  = 8;
  localparam int TAG_ID_W  = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [TAG_ID_W-1:0] id);
    logic [NREQ_MAX-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//  req      in   NREQ   request vector
//  ptr      in   ID_W   id of the most recently served requester
//  grant    out  NREQ   one-hot grant (zero when no request)
//  grant_id out  ID_W   index of the granted requester (0 when none)
//  any      out  1      at least one request present
// Priority starts at ptr+1 and wraps modulo NREQ, so the requester served
// last has the lowest priority on the next decision.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_id   = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/myproject_mul_share_sched.sv
// Time-shares one pipelined signed multiplier among NREQ requesters.
// Operand requests are arbitrated round-robin, at most one product is issued
// per cycle, a requester tag rides alongside the multiplier pipeline, and the
// product at the pipe tail is routed back to its requester.
//
// Ports
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-low reset
//  req_valid  in   NREQ        per-requester operand valid
//  req_ready  out  NREQ        per-requester accept (one-hot or zero)
//  req_a/b    in   NREQ*IN_W   operands, requester i at [i*IN_W +: IN_W]
//  rsp_valid  out  NREQ        result valid (one-hot or zero)
//  rsp_ready  in   NREQ        per-requester result accept
//  rsp_data   out  OUT_W       result, shared, qualified by rsp_valid
//  mul_ce     out  1           multiplier clock enable
//  mul_din0/1 out  IN_W        multiplier operands
//  mul_dout   in   OUT_W       multiplier product (MUL_LAT ce-cycles later)
//  inflight   out  ID_W+2      valid tags currently in the pipe
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Requesters hold operands and valid until ready; results are held
// stable on rsp_data/rsp_valid until the addressed rsp_ready is seen. Ready
// never depends combinationally on the same requester's valid being accepted
// elsewhere: mul_ce depends only on the tail tag and rsp_ready.
module myproject_mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IN_W-1:0] req_a,
  input  logic [NREQ*IN_W-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [OUT_W-1:0]     rsp_data,
  output logic                 mul_ce,
  output logic [IN_W-1:0]      mul_din0,
  output logic [IN_W-1:0]      mul_din1,
  input  logic [OUT_W-1:0]     mul_dout,
  output logic [ID_W+1:0]      inflight
);

  // Reset: asserted asynchronously, released synchronously through two flops.
  logic [1:0] rst_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_int_n = rst_q[1];

  // Tag pipe, stage MUL_LAT-1 is the tail aligned with mul_dout.
  tag_t [MUL_LAT-1:0] tags;
  tag_t               tail;
  tag_t               new_tag;
  logic [ID_W-1:0]    rr_ptr;

  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic               stall;
  logic               issue;
  logic               pop;

  assign tail = tags[MUL_LAT-1];

  // Only a valid tail whose requester refuses the result freezes the pipe;
  // bubbles at the tail always advance.
  assign stall  = tail.vld & ~rsp_ready[tail.id[ID_W-1:0]];
  assign mul_ce = ~stall;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // No acceptance while stalled or while the internal reset is still held.
  assign req_ready = grant & {NREQ{mul_ce & rst_int_n}};
  assign issue     = |(req_valid & req_ready);
  assign pop       = tail.vld & mul_ce;

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (grant_any) begin
      mul_din0 = req_a[grant_id*IN_W +: IN_W];
      mul_din1 = req_b[grant_id*IN_W +: IN_W];
    end
  end

  always_comb begin
    new_tag     = '0;
    new_tag.vld = issue;
    new_tag.id  = TAG_ID_W'(grant_id);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tags     <= '0;
      rr_ptr   <= ID_W'(NREQ - 1);
      inflight <= '0;
    end else begin
      if (mul_ce) tags <= {tags[MUL_LAT-2:0], new_tag};
      if (issue)  rr_ptr <= grant_id;
      case ({issue, pop})
        2'b10:   inflight <= inflight + (ID_W+2)'(1);
        2'b01:   inflight <= inflight - (ID_W+2)'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign rsp_valid = tail.vld ? NREQ'(onehot(tail.id)) : '0;
  assign rsp_data  = mul_dout;

endmodule

// File: tb/tb_myproject_mul_share_sched.sv
// Bench for myproject_mul_share_sched. The shared multiplier is modelled as
// a MUL_LAT-deep ce-gated pipe; a scoreboard tracks every accepted operand
// pair and checks each returned result in order.
module tb_myproject_mul_share_sched;

  localparam int NREQ  = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 58;
  localparam int LAT   = 4;
  localparam int ID_W  = 2;
  localparam int SB_W  = ID_W + OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IN_W-1:0] req_a;
  logic [NREQ*IN_W-1:0] req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [OUT_W-1:0]     rsp_data;
  logic                 mul_ce;
  logic [IN_W-1:0]      mul_din0;
  logic [IN_W-1:0]      mul_din1;
  logic [OUT_W-1:0]     mul_dout;
  logic [ID_W+1:0]      inflight;

  myproject_mul_share_sched #(
    .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .MUL_LAT(LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .inflight(inflight)
  );

  function automatic logic [OUT_W-1:0] mul58(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[OUT_W-1:0];
  endfunction

  // Multiplier model: ce-gated pipe, data regs not reset.
  logic [OUT_W-1:0] mst [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mst[0] <= mul58(mul_din0, mul_din1);
      for (int i = 1; i < LAT; i++) mst[i] <= mst[i-1];
    end
  end
  assign mul_dout = mst[LAT-1];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    #1;
  endtask

  // Samples both handshakes just before the edge, then advances one cycle.
  task automatic tick();
    int rid;
    logic [SB_W-1:0] e;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i])
        exp_q.push_back({ID_W'(i), mul58(req_a[i*IN_W +: IN_W], req_b[i*IN_W +: IN_W])});
    if (|(rsp_valid & rsp_ready)) begin
      rid = 0;
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rid = i;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", {ID_W'(rid), rsp_data});
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp", 64'({ID_W'(rid), rsp_data}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    req_a[id*IN_W +: IN_W] = a;
    req_b[id*IN_W +: IN_W] = b;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    repeat (3) tick();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int               id;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic [NREQ-1:0]  vld_oh;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] oh;

    vecs[0] = '{0, 32'd3,        32'hFFFFFFFB, 4'b0001, 58'h3FFFFFFFFFFFFF1};
    vecs[1] = '{1, 32'h7FFFFFFF, 32'h80000000, 4'b0010, 58'h000000080000000};
    vecs[2] = '{2, 32'h80000000, 32'h80000000, 4'b0100, 58'h000000000000000};
    vecs[3] = '{3, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b1000, 58'h3FFFFFF00000001};
    vecs[4] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 58'h000000000000001};
    vecs[5] = '{1, 32'd12345,    32'hFFFFFFFF, 4'b0010, 58'h3FFFFFFFFFFCFC7};
    vecs[6] = '{2, 32'h00010000, 32'h00010000, 4'b0100, 58'h000000100000000};

    // Reset state, with every requester asking.
    reset     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mul_ce", mul_ce, 1);
    check("rst_inflight", inflight, 0);
    do_reset();

    // Single issues through an idle pipe: latency and arithmetic corners.
    for (int v = 0; v < 7; v++) begin
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = NREQ'(1) << vecs[v].id;
      settle();
      check("vec_ready", req_ready, vecs[v].vld_oh);
      tick();
      req_valid = '0;
      for (int k = 1; k < LAT; k++) begin
        settle();
        check("vec_early", rsp_valid, 0);
        tick();
      end
      settle();
      check("vec_rsp_valid", rsp_valid, vecs[v].vld_oh);
      check("vec_rsp_data", rsp_data, vecs[v].exp);
      tick();
    end

    // All requesters continuously valid: 0,1,2,3,0,... with no gaps.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, IN_W'(i + 10), -IN_W'(i + 1));
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      settle();
      oh = NREQ'(1) << (c % NREQ);
      check("rr_grant", req_ready, oh);
      if (c >= LAT) begin
        check("rr_inflight", inflight, LAT);
        check("rr_rsp_order", rsp_valid, oh);
      end
      tick();
    end
    req_valid = '0;
    repeat (LAT + 1) tick();
    check("rr_drain", exp_q.size(), 0);

    // Stall: tail id 2 refused for 3 cycles.
    set_ops(2, 32'd7, 32'd6);
    req_valid = 4'b0100;
    settle();
    check("st_issue2", req_ready, 4'b0100);
    tick();
    set_ops(3, 32'd5, 32'd5);
    req_valid = 4'b1000;
    settle();
    check("st_issue3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (2) tick();
    set_ops(0, 32'd1, 32'd9);
    req_valid = 4'b0001;
    rsp_ready = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("st_rsp_valid", rsp_valid, 4'b0100);
      check("st_mul_ce", mul_ce, 0);
      check("st_req_ready", req_ready, 0);
      check("st_data_held", rsp_data, 58'd42);
      check("st_inflight", inflight, 2);
      tick();
    end
    rsp_ready = '1;
    settle();
    check("st_release_rsp", rsp_valid, 4'b0100);
    check("st_release_ce", mul_ce, 1);
    check("st_release_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    settle();
    check("st_next_rsp", rsp_valid, 4'b1000);
    check("st_next_data", rsp_data, 58'd25);
    tick();
    repeat (LAT + 1) tick();
    check("st_drain", exp_q.size(), 0);

    // Reset with three tags in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_ops(i, IN_W'(i + 1), IN_W'(i + 3));
      req_valid = NREQ'(1) << i;
      tick();
    end
    req_valid = '0;
    tick();
    settle();
    check("rr_pre_rsp", rsp_valid, 4'b0001);
    check("rr_pre_inflight", inflight, 3);
    reset = 1'b0;
    #1;
    check("rst_mid_rsp", rsp_valid, 0);
    check("rst_mid_inflight", inflight, 0);
    check("rst_mid_ce", mul_ce, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    set_ops(1, 32'd2, 32'd2);
    req_valid = 4'b0010;
    settle();
    check("rst_new_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int k = 1; k < LAT; k++) begin
      settle();
      check("rst_no_stale", rsp_valid, 0);
      tick();
    end
    settle();
    check("rst_new_rsp", rsp_valid, 4'b0010);
    check("rst_new_data", rsp_data, 58'd4);
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rst_quiet", rsp_valid, 0);
      tick();
    end

    // Pointer wrap: after req2 is served, req0 beats req2.
    do_reset();
    set_ops(0, 32'd11, 32'd3);
    set_ops(2, 32'd13, 32'hFFFFFFFE);
    req_valid = 4'b0100;
    settle();
    check("wrap_first", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0101;
    settle();
    check("wrap_to0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    settle();
    check("wrap_back2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0101;
    settle();
    check("wrap_again0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (LAT + 2) tick();
    check("wrap_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
